// File: rtl/conv2d.sv
// Parallel 2-D valid convolution: TOTSUBIMAGEM lanes each sweep a horizontal strip of
// output rows, one pixel per lane per cycle, then the block parks in DONE until reset.
module conv2d #(
  parameter int SIZE         = 512,
  parameter int SIZEKer      = 3,
  parameter int WIDTH_BIT    = 8,
  parameter int TOTSUBIMAGEM = 64,
  parameter logic [SIZEKer*SIZEKer*WIDTH_BIT-1:0] KERNEL = {(SIZEKer*SIZEKer){WIDTH_BIT'(1)}}
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE-1:0][SIZE-1:0],
  output logic                        done,
  output logic signed [WIDTH_BIT-1:0] convIxKernelOut [SIZE-SIZEKer:0][SIZE-SIZEKer:0],
  output logic [1:0]                  state_o
);

  localparam int OUT   = SIZE - SIZEKer + 1;
  localparam int ROWS  = (OUT + TOTSUBIMAGEM - 1) / TOTSUBIMAGEM;
  localparam int ACC_W = 2 * WIDTH_BIT + $clog2(SIZEKer * SIZEKer);
  localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int OW    = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rloc_q, rloc_d;
  logic [OW-1:0] col_q, col_d;

  logic signed [WIDTH_BIT-1:0] out_q [SIZE-SIZEKer:0][SIZE-SIZEKer:0];

  logic                        lane_act [TOTSUBIMAGEM];
  logic [OW-1:0]               lane_row [TOTSUBIMAGEM];
  logic signed [WIDTH_BIT-1:0] lane_pix [TOTSUBIMAGEM];

  // Full-precision sum of the window anchored at (row, col), wrapped to WIDTH_BIT.
  function automatic logic signed [WIDTH_BIT-1:0] conv_pixel(input int row, input int col);
    logic signed [ACC_W-1:0]       acc;
    logic signed [2*WIDTH_BIT-1:0] prod;
    logic signed [WIDTH_BIT-1:0]   pix;
    logic signed [WIDTH_BIT-1:0]   ker;
    acc = '0;
    for (int r = 0; r < SIZEKer; r++) begin
      for (int c = 0; c < SIZEKer; c++) begin
        pix  = inpMatrixI[IW'(row + r)][IW'(col + c)];
        ker  = KERNEL[(r*SIZEKer+c)*WIDTH_BIT +: WIDTH_BIT];
        prod = (2*WIDTH_BIT)'(pix) * (2*WIDTH_BIT)'(ker);
        acc  = acc + ACC_W'(prod);
      end
    end
    return acc[WIDTH_BIT-1:0];
  endfunction

  // Lanes whose strip row falls past the last output row sit idle (address held at 0).
  always_comb begin
    for (int l = 0; l < TOTSUBIMAGEM; l++) begin
      lane_act[l] = (state_q == RUN) && ((l*ROWS + int'(rloc_q)) < OUT);
      lane_row[l] = lane_act[l] ? OW'(l*ROWS + int'(rloc_q)) : '0;
      lane_pix[l] = conv_pixel(int'(lane_row[l]), int'(col_q));
    end
  end

  always_comb begin
    state_d = state_q;
    rloc_d  = rloc_q;
    col_d   = col_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (col_q == OW'(OUT - 1)) begin
          col_d = '0;
          if (rloc_q == RW'(ROWS - 1)) begin
            state_d = DONE;
            rloc_d  = '0;
          end else begin
            rloc_d = rloc_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      rloc_q  <= '0;
      col_q   <= '0;
      for (int i = 0; i < OUT; i++) begin
        for (int j = 0; j < OUT; j++) begin
          out_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      rloc_q  <= rloc_d;
      col_q   <= col_d;
      for (int l = 0; l < TOTSUBIMAGEM; l++) begin
        if (lane_act[l]) out_q[lane_row[l]][col_q] <= lane_pix[l];
      end
    end
  end

  assign convIxKernelOut = out_q;
  assign done            = (state_q == DONE);
  assign state_o         = state_q;

endmodule

// File: tb/tb_conv2d.sv
// Bench for conv2d: three instances (all-ones kernel, centre kernel, 4x4 corner kernel)
// share clock and reset; results are compared to a direct window-sum model.
module tb_conv2d;

  logic clock  = 1'b0;
  logic nreset = 1'b1;

  logic signed [7:0] img_a [4:0][4:0];
  logic signed [7:0] img_b [4:0][4:0];
  logic signed [7:0] img_c [3:0][3:0];
  logic signed [7:0] out_a [2:0][2:0];
  logic signed [7:0] out_b [2:0][2:0];
  logic signed [7:0] out_c [0:0][0:0];
  logic              done_a, done_b, done_c;
  logic [1:0]        st_a, st_b, st_c;

  int ka [3][3];
  int kb [3][3];
  int kc [4][4];

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  conv2d #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(8), .TOTSUBIMAGEM(2)) u_a (
    .clock(clock), .nreset(nreset), .inpMatrixI(img_a), .done(done_a),
    .convIxKernelOut(out_a), .state_o(st_a));

  conv2d #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(8), .TOTSUBIMAGEM(2),
           .KERNEL(72'h000000000100000000)) u_b (
    .clock(clock), .nreset(nreset), .inpMatrixI(img_b), .done(done_b),
    .convIxKernelOut(out_b), .state_o(st_b));

  conv2d #(.SIZE(4), .SIZEKer(4), .WIDTH_BIT(8), .TOTSUBIMAGEM(1),
           .KERNEL(128'h1)) u_c (
    .clock(clock), .nreset(nreset), .inpMatrixI(img_c), .done(done_c),
    .convIxKernelOut(out_c), .state_o(st_c));

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic apply_reset();
    @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
  endtask

  // Release reset and record the cycle (posedges after release) where each done rises.
  task automatic run_measure(output int ca, output int cb, output int cc);
    ca = 0; cb = 0; cc = 0;
    @(negedge clock);
    nreset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (done_a === 1'b1 && ca == 0) ca = k;
      if (done_b === 1'b1 && cb == 0) cb = k;
      if (done_c === 1'b1 && cc == 0) cc = k;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic randomize_imgs();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        img_a[i][j] = 8'($urandom_range(0, 255));
        img_b[i][j] = 8'($urandom_range(0, 255));
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        img_c[i][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_a(input int v);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        img_a[i][j] = 8'(v);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_a(input int i, input int j);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'(img_a[i+r][j+c]) * ka[r][c];
    return 8'(s);
  endfunction

  function automatic logic [7:0] ref_b(input int i, input int j);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'(img_b[i+r][j+c]) * kb[r][c];
    return 8'(s);
  endfunction

  function automatic logic [7:0] ref_c();
    int s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s += int'(img_c[r][c]) * kc[r][c];
    return 8'(s);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    randomize_imgs();
    #1 nreset = 1'b0;
    #1;
    vectors++;
    if ({done_a, done_b, done_c} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_done got %b exp 000", {done_a, done_b, done_c});
    end
    vectors++;
    if ({st_a, st_b, st_c} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_state got %b exp 000000", {st_a, st_b, st_c});
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (out_a[i][j] !== 8'd0 || out_b[i][j] !== 8'd0) begin
          miscompares++;
          $display("FAIL reset_out[%0d][%0d] got %h/%h exp 00", i, j, out_a[i][j], out_b[i][j]);
        end
      end
    vectors++;
    if (out_c[0][0] !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_out_c got %h exp 00", out_c[0][0]);
    end
  endtask

  task automatic test_ones();
    int ca, cb, cc;
    fill_a(1);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        img_b[i][j] = 8'(5*i + j);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        img_c[i][j] = 8'($urandom_range(0, 255));
    apply_reset();
    run_measure(ca, cb, cc);
    vectors++;
    if (ca !== 7 || cb !== 7) begin
      miscompares++;
      $display("FAIL latency_5x5 got %0d/%0d exp 7", ca, cb);
    end
    vectors++;
    if (cc !== 2) begin
      miscompares++;
      $display("FAIL latency_4x4 got %0d exp 2", cc);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (out_a[i][j] !== 8'd9) begin
          miscompares++;
          $display("FAIL ones_a[%0d][%0d] got %h exp 09", i, j, out_a[i][j]);
        end
        vectors++;
        if (out_b[i][j] !== 8'(5*(i+1) + (j+1))) begin
          miscompares++;
          $display("FAIL center_b[%0d][%0d] got %0d exp %0d", i, j, out_b[i][j], 5*(i+1)+(j+1));
        end
      end
    vectors++;
    if (out_c[0][0] !== img_c[0][0]) begin
      miscompares++;
      $display("FAIL corner_c got %h exp %h", out_c[0][0], img_c[0][0]);
    end
    vectors++;
    if (st_a !== 2'd2) begin
      miscompares++;
      $display("FAIL done_state got %0d exp 2", st_a);
    end
  endtask

  task automatic test_wrap();
    int ca, cb, cc;
    logic [7:0] want [2];
    want[0] = 8'h77;
    want[1] = 8'h80;
    for (int p = 0; p < 2; p++) begin
      fill_a(p == 0 ? 127 : -128);
      apply_reset();
      run_measure(ca, cb, cc);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          vectors++;
          if (out_a[i][j] !== want[p]) begin
            miscompares++;
            $display("FAIL wrap%0d[%0d][%0d] got %h exp %h", p, i, j, out_a[i][j], want[p]);
          end
        end
    end
  endtask

  task automatic test_random();
    int ca, cb, cc;
    logic [7:0] e;
    for (int it = 0; it < 5; it++) begin
      randomize_imgs();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          exp_q.push_back(ref_a(i, j));
          exp_q.push_back(ref_b(i, j));
        end
      exp_q.push_back(ref_c());
      apply_reset();
      run_measure(ca, cb, cc);
      vectors++;
      if (ca !== 7 || cc !== 2) begin
        miscompares++;
        $display("FAIL rand_latency got %0d/%0d exp 7/2", ca, cc);
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          e = exp_q.pop_front();
          vectors++;
          if (out_a[i][j] !== e) begin
            miscompares++;
            $display("FAIL rand_a[%0d][%0d] got %h exp %h", i, j, out_a[i][j], e);
          end
          e = exp_q.pop_front();
          vectors++;
          if (out_b[i][j] !== e) begin
            miscompares++;
            $display("FAIL rand_b[%0d][%0d] got %h exp %h", i, j, out_b[i][j], e);
          end
        end
      e = exp_q.pop_front();
      vectors++;
      if (out_c[0][0] !== e) begin
        miscompares++;
        $display("FAIL rand_c got %h exp %h", out_c[0][0], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ca, cb, cc;
    logic [7:0] e;
    randomize_imgs();
    apply_reset();
    @(negedge clock);
    nreset = 1'b1;
    repeat (3) @(posedge clock);
    #2 nreset = 1'b0;
    #1;
    vectors++;
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_done got %b%b exp 00", done_a, done_b);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (out_a[i][j] !== 8'd0) begin
          miscompares++;
          $display("FAIL midreset_clear[%0d][%0d] got %h exp 00", i, j, out_a[i][j]);
        end
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        exp_q.push_back(ref_a(i, j));
    run_measure(ca, cb, cc);
    vectors++;
    if (ca !== 7) begin
      miscompares++;
      $display("FAIL midreset_latency got %0d exp 7", ca);
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        e = exp_q.pop_front();
        vectors++;
        if (out_a[i][j] !== e) begin
          miscompares++;
          $display("FAIL midreset_a[%0d][%0d] got %h exp %h", i, j, out_a[i][j], e);
        end
      end
  endtask

  task automatic test_hold();
    int ca, cb, cc;
    logic [7:0] e;
    randomize_imgs();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        exp_q.push_back(ref_b(i, j));
    apply_reset();
    run_measure(ca, cb, cc);
    for (int k = 0; k < 3; k++) begin
      randomize_imgs();
      repeat (2) @(posedge clock);
    end
    #1;
    vectors++;
    if ({done_a, done_b, done_c} !== 3'b111) begin
      miscompares++;
      $display("FAIL hold_done got %b exp 111", {done_a, done_b, done_c});
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        e = exp_q.pop_front();
        vectors++;
        if (out_b[i][j] !== e) begin
          miscompares++;
          $display("FAIL hold_b[%0d][%0d] got %h exp %h", i, j, out_b[i][j], e);
        end
      end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ka[r][c] = 1;
        kb[r][c] = (r == 1 && c == 1) ? 1 : 0;
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        kc[r][c] = (r == 0 && c == 0) ? 1 : 0;

    test_reset();
    test_ones();
    test_wrap();
    test_random();
    test_reset_mid();
    test_hold();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
